i2c_target_regfile: RTL and testbench



---
 rtl/i2c_tgt_pkg.sv | 25 ++
 rtl/i2c_tgt_line_cond.sv | 93 +++++++++
 rtl/i2c_target_regfile.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C target register file.
// Optional build macro: I2C_TGT_GLITCH_FILTER_EN (see line conditioner).
package i2c_tgt_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_e;

  localparam logic ACK     = 1'b0;
  localparam logic NACK    = 1'b1;
  localparam logic SDA_REL = 1'b1;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_tgt_line_cond.sv
// SCL/SDA synchroniser, optional majority filter and bus-event detect.
// Define I2C_TGT_GLITCH_FILTER_EN to add the 3-sample filter (+2 PCLK).
module i2c_tgt_line_cond
  import i2c_tgt_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       scl_c, sda_c;

  // Two-stage synchroniser shift for the asynchronous pads
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
  end

  // Synchroniser flops; idle bus level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [2:0] scl_h_q, scl_h_d;
  logic [2:0] sda_h_q, sda_h_d;

  // Sample history feeding the majority vote
  always_comb begin
    scl_h_d = {scl_h_q[1:0], scl_sync_q[1]};
    sda_h_d = {sda_h_q[1:0], sda_sync_q[1]};
  end

  // History flops; a lone 1-PCLK pulse never wins the vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_h_q <= 3'b111;
      sda_h_q <= 3'b111;
    end else begin
      scl_h_q <= scl_h_d;
      sda_h_q <= sda_h_d;
    end
  end

  assign scl_c = maj3(scl_h_q);
  assign sda_c = maj3(sda_h_q);
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  // Previous-value capture for edge detection
  always_comb begin
    scl_prev_d = scl_c;
    sda_prev_d = sda_c;
  end

  // Previous-value flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_rise  = scl_c & ~scl_prev_q;
  assign scl_fall  = ~scl_c & scl_prev_q;
  assign start_det = scl_c & scl_prev_q
                   & sda_prev_q & ~sda_c;
  assign stop_det  = scl_c & scl_prev_q
                   & ~sda_prev_q & sda_c;
  assign sda_s     = sda_c;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with auto-incrementing pointer into a byte register file.
// Build option I2C_TGT_GLITCH_FILTER_EN enables SCL/SDA glitch filtering.
module i2c_target_regfile
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0] TGT_ADDR = 7'h50,
  parameter int         NUM_REGS = 8,
  parameter int         PTR_W    = 3
) (
  input  logic             PCLK,
  input  logic             PRESETN,
  input  logic             SCLI,
  input  logic             SDAI,
  output logic             SDAO,
  input  logic [PTR_W-1:0] RD_ADDR,
  output logic [7:0]       RD_DATA,
  output logic             WR_STB,
  output logic [PTR_W-1:0] WR_ADDR,
  output logic [7:0]       WR_DATA,
  output logic             INT,
  input  logic             INT_CLR
);

  logic scl_rise, scl_fall;
  logic start_det, stop_det, sda_s;

  i2c_tgt_line_cond u_line (
    .clk       (PCLK),
    .rst_n     (PRESETN),
    .scl_i     (SCLI),
    .sda_i     (SDAI),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       sh_q, sh_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rw_q, rw_d;
  logic             ph_q, ph_d;
  logic             sdao_q, sdao_d;
  logic             int_q, int_d;
  logic             seen_q, seen_d;
  logic             stb_q, stb_d;
  logic [PTR_W-1:0] wa_q, wa_d;
  logic [7:0]       wd_q, wd_d;
  logic [7:0]       regs_q [NUM_REGS];
  logic [7:0]       regs_d [NUM_REGS];

  logic [7:0]       sh_in;
  logic [PTR_W-1:0] ptr_inc;
  logic             last_bit;
  logic             ptr_ok;

  assign sh_in    = {sh_q[6:0], sda_s};
  assign last_bit = (cnt_q == 3'd7);
  assign ptr_ok   = ({1'b0, sh_in} < 9'(NUM_REGS));
  assign ptr_inc  = (ptr_q == PTR_W'(NUM_REGS - 1))
                  ? '0 : ptr_q + PTR_W'(1);

  // Protocol FSM: next state, shift/pointer, SDA drive, regfile write
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    ph_d    = ph_q;
    sdao_d  = sdao_q;
    int_d   = int_q;
    seen_d  = seen_q;
    stb_d   = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    regs_d  = regs_q;
    if (INT_CLR) int_d = 1'b0;
    if (start_det || stop_det) begin
      sdao_d  = SDA_REL;
      cnt_d   = '0;
      ph_d    = 1'b0;
      state_d = start_det ? ADDR : IDLE;
      if (stop_det && seen_q) begin
        int_d  = 1'b1;
        seen_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: if (scl_rise) begin
          sh_d  = sh_in;
          cnt_d = cnt_q + 3'd1;
          if (last_bit) begin
            rw_d    = sh_in[0];
            state_d = (sh_in[7:1] == TGT_ADDR)
                    ? ADDR_ACK : IDLE;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!ph_q) begin
            sdao_d = ACK;
            ph_d   = 1'b1;
          end else begin
            ph_d   = 1'b0;
            sdao_d = SDA_REL;
            if (rw_q) begin
              state_d = RDATA;
              sh_d    = regs_q[ptr_q];
              sdao_d  = regs_q[ptr_q][7];
            end else begin
              state_d = PTR;
            end
          end
        end
        PTR: if (scl_rise) begin
          sh_d  = sh_in;
          cnt_d = cnt_q + 3'd1;
          if (last_bit) begin
            if (ptr_ok) begin
              ptr_d   = sh_in[PTR_W-1:0];
              state_d = PTR_ACK;
            end else begin
              sdao_d  = NACK;
              state_d = IDLE;
            end
          end
        end
        PTR_ACK: if (scl_fall) begin
          if (!ph_q) begin
            sdao_d = ACK;
            ph_d   = 1'b1;
          end else begin
            sdao_d  = SDA_REL;
            ph_d    = 1'b0;
            state_d = WDATA;
          end
        end
        WDATA: if (scl_rise) begin
          sh_d  = sh_in;
          cnt_d = cnt_q + 3'd1;
          if (last_bit) state_d = WDATA_ACK;
        end
        WDATA_ACK: if (scl_fall) begin
          if (!ph_q) begin
            sdao_d        = ACK;
            ph_d          = 1'b1;
            regs_d[ptr_q] = sh_q;
            stb_d         = 1'b1;
            wa_d          = ptr_q;
            wd_d          = sh_q;
            seen_d        = 1'b1;
            ptr_d         = ptr_inc;
          end else begin
            sdao_d  = SDA_REL;
            ph_d    = 1'b0;
            state_d = WDATA;
          end
        end
        RDATA: begin
          if (scl_fall) sdao_d = sh_q[7];
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (last_bit) state_d = RDATA_ACK;
          end
        end
        RDATA_ACK: begin
          if (scl_fall && !ph_q) begin
            sdao_d = SDA_REL;
            ph_d   = 1'b1;
          end
          if (scl_rise && ph_q) begin
            ph_d = 1'b0;
            if (sda_s == ACK) begin
              ptr_d   = ptr_inc;
              sh_d    = regs_q[ptr_inc];
              state_d = RDATA;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, datapath and register file flops
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ptr_q   <= '0;
      rw_q    <= 1'b0;
      ph_q    <= 1'b0;
      sdao_q  <= SDA_REL;
      int_q   <= 1'b0;
      seen_q  <= 1'b0;
      stb_q   <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      ph_q    <= ph_d;
      sdao_q  <= sdao_d;
      int_q   <= int_d;
      seen_q  <= seen_d;
      stb_q   <= stb_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      regs_q  <= regs_d;
    end
  end

  assign SDAO    = sdao_q;
  assign RD_DATA = regs_q[RD_ADDR];
  assign WR_STB  = stb_q;
  assign WR_ADDR = wa_q;
  assign WR_DATA = wd_q;
  assign INT     = int_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Randomised I2C controller stimulus against a transaction-level model.
// Directed cases pin the model with literal expectations.
module tb_i2c_target_regfile;

  localparam int Q = 6;
`ifdef I2C_TGT_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic       PCLK = 1'b0;
  logic       PRESETN = 1'b0;
  logic       SCLI, SDAI, SDAO;
  logic [2:0] RD_ADDR = '0;
  logic [7:0] RD_DATA;
  logic       WR_STB;
  logic [2:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic       INT;
  logic       INT_CLR = 1'b0;

  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  assign SCLI = scl_m;
  assign SDAI = sda_m & SDAO;

  always #5 PCLK = ~PCLK;

  i2c_target_regfile dut (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .SCLI    (SCLI),
    .SDAI    (SDAI),
    .SDAO    (SDAO),
    .RD_ADDR (RD_ADDR),
    .RD_DATA (RD_DATA),
    .WR_STB  (WR_STB),
    .WR_ADDR (WR_ADDR),
    .WR_DATA (WR_DATA),
    .INT     (INT),
    .INT_CLR (INT_CLR)
  );

  int checks = 0;
  int errors = 0;
  int nstb = 0;

  logic [7:0]  mregs [8];
  int          mptr = 0;
  bit          mint = 0;
  bit          mseen = 0;
  logic [10:0] expq [$];
  logic [10:0] exp_w;
  bit          chk_idle = 0;
  bit          clr_on_stop = 0;
  logic [7:0]  wbuf [4];
  logic [7:0]  rbuf [4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (WR_STB) begin
      nstb++;
      if (expq.size() == 0) begin
        chk("wr_stb_unexpected", WR_STB, 0);
      end else begin
        exp_w = expq.pop_front();
        chk("wr_addr", WR_ADDR, exp_w[10:8]);
        chk("wr_data", WR_DATA, exp_w[7:0]);
      end
    end
    if (chk_idle) begin
      chk("rd_data", RD_DATA, mregs[RD_ADDR]);
      chk("int", INT, mint);
      chk("sdao_idle", SDAO, 1);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic wq();
    repeat (Q) @(posedge PCLK);
    #1;
  endtask

  task automatic bit_io(input logic b, output logic s);
    wq(); sda_m = b;
    wq(); scl_m = 1'b1;
    wq(); s = SDAI;
    wq(); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    chk_idle = 0;
    if (!scl_m) begin
      wq(); sda_m = 1'b1;
      wq(); scl_m = 1'b1;
      wq();
    end
    sda_m = 1'b0;
    wq(); wq(); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wq(); sda_m = 1'b0;
    wq(); scl_m = 1'b1;
    wq(); sda_m = 1'b1;
    if (clr_on_stop) begin
      repeat (LAT - 1) @(posedge PCLK);
      #1 INT_CLR = 1'b1;
      @(posedge PCLK);
      #1 INT_CLR = 1'b0;
    end
    wq(); wq();
    if (mseen) begin
      mint = 1;
      mseen = 0;
    end
    chk("expq_empty", expq.size(), 0);
    chk_idle = 1;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           output logic a);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, a);
  endtask

  task automatic recv_byte(input logic nack,
                           output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      d[i] = s;
    end
    bit_io(nack, s);
  endtask

  task automatic wr_txn(input logic [7:0] ab,
                        input logic [7:0] p,
                        input int n);
    logic a;
    bit m;
    m = (ab[7:1] == 7'h50);
    i2c_start();
    send_byte(ab, a);
    chk("addr_ack", a, m ? 0 : 1);
    if (m) begin
      send_byte(p, a);
      chk("ptr_ack", a, (p < 8) ? 0 : 1);
      if (p < 8) begin
        mptr = int'(p);
        for (int i = 0; i < n; i++) begin
          expq.push_back({3'(mptr), wbuf[i]});
          mregs[mptr] = wbuf[i];
          mptr = (mptr + 1) % 8;
          mseen = 1;
          send_byte(wbuf[i], a);
          chk("data_ack", a, 0);
        end
      end
    end
    i2c_stop();
  endtask

  task automatic rd_txn(input logic [7:0] p,
                        input int n);
    logic a;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hA0, a);
    chk("rd_addr_ack", a, 0);
    send_byte(p, a);
    chk("rd_ptr_ack", a, (p < 8) ? 0 : 1);
    if (p < 8) begin
      mptr = int'(p);
      i2c_start();
      send_byte(8'hA1, a);
      chk("rd_addr1_ack", a, 0);
      for (int i = 0; i < n; i++) begin
        recv_byte(i == n - 1, d);
        chk("rd_byte", d, mregs[mptr]);
        rbuf[i] = d;
        if (i != n - 1) mptr = (mptr + 1) % 8;
      end
    end
    i2c_stop();
  endtask

  task automatic int_clear();
    @(posedge PCLK);
    #1 INT_CLR = 1'b1;
    @(posedge PCLK);
    #1 INT_CLR = 1'b0;
    mint = 0;
  endtask

  task automatic idle_gap(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1 RD_ADDR = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic peek(input logic [2:0] ra,
                      input logic [7:0] ev,
                      input string nm);
    RD_ADDR = ra;
    #1 chk(nm, RD_DATA, ev);
  endtask

  initial begin
    logic a;
    logic s;
    int n0;
    int kind;
    for (int i = 0; i < 8; i++) mregs[i] = '0;

    // reset state
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_sdao", SDAO, 1);
    chk("rst_int", INT, 0);
    chk("rst_wr_stb", WR_STB, 0);
    chk("rst_wr_addr", WR_ADDR, 0);
    chk("rst_wr_data", WR_DATA, 0);
    PRESETN = 1'b1;
    for (int r = 0; r < 8; r++)
      peek(3'(r), 8'h00, "rst_reg");
    idle_gap(4);
    chk_idle = 1;

    // write two bytes from pointer 2
    wbuf[0] = 8'h5A;
    wbuf[1] = 8'hC3;
    n0 = nstb;
    wr_txn(8'hA0, 8'h02, 2);
    chk("wr_stb_count", nstb - n0, 2);
    peek(3'd2, 8'h5A, "reg2_lit");
    peek(3'd3, 8'hC3, "reg3_lit");
    chk("int_after_wr", INT, 1);

    // pointer then repeated-start read
    rd_txn(8'h02, 2);
    chk("rd0_lit", rbuf[0], 8'h5A);
    chk("rd1_lit", rbuf[1], 8'hC3);
    chk("int_after_rd", INT, 1);

    // address mismatch, bus ignored
    n0 = nstb;
    i2c_start();
    send_byte(8'hA2, a);
    chk("mismatch_ack", a, 1);
    send_byte(8'h00, a);
    chk("ignored_ack", a, 1);
    i2c_stop();
    chk("mismatch_stb", nstb - n0, 0);

    // pointer out of range, then wrap
    wr_txn(8'hA0, 8'h08, 1);
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    wr_txn(8'hA0, 8'h07, 2);
    peek(3'd7, 8'h11, "reg7_lit");
    peek(3'd0, 8'h22, "reg0_wrap_lit");

    // stop mid data byte
    int_clear();
    n0 = nstb;
    i2c_start();
    send_byte(8'hA0, a);
    chk("abort_addr_ack", a, 0);
    send_byte(8'h04, a);
    chk("abort_ptr_ack", a, 0);
    mptr = 4;
    for (int i = 0; i < 4; i++) bit_io(1'b1, s);
    i2c_stop();
    chk("abort_stb", nstb - n0, 0);
    chk("abort_sdao", SDAO, 1);
    chk("abort_int", INT, 0);
    wbuf[0] = 8'h77;
    wr_txn(8'hA0, 8'h05, 1);
    peek(3'd5, 8'h77, "reg5_lit");
    chk("int_after_abort", INT, 1);

    // INT_CLR in the same cycle as the STOP set
    int_clear();
    wbuf[0] = 8'h3C;
    clr_on_stop = 1;
    wr_txn(8'hA0, 8'h01, 1);
    clr_on_stop = 0;
    chk("int_set_wins", INT, 1);

    // reset while driving read data low
    wbuf[0] = 8'h5A;
    wr_txn(8'hA0, 8'h02, 1);
    i2c_start();
    send_byte(8'hA0, a);
    send_byte(8'h02, a);
    i2c_start();
    send_byte(8'hA1, a);
    chk("rd_rst_addr_ack", a, 0);
    wq();
    chk("rdata_drive_low", SDAO, 0);
    PRESETN = 1'b0;
    #1 chk("rst_sdao_async", SDAO, 1);
    for (int r = 0; r < 8; r++)
      peek(3'(r), 8'h00, "rst_mid_reg");
    chk("rst_mid_int", INT, 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mptr = 0;
    mint = 0;
    mseen = 0;
    expq.delete();
    repeat (3) @(posedge PCLK);
    #1 PRESETN = 1'b1;
    idle_gap(4);
    chk_idle = 1;

    // randomised traffic
    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 9));
      for (int i = 0; i < 4; i++)
        wbuf[i] = 8'($urandom);
      if (kind <= 4) begin
        if ($urandom_range(0, 5) == 0)
          wr_txn({7'($urandom_range(0, 127)), 1'b0},
                 8'($urandom_range(0, 9)),
                 int'($urandom_range(1, 3)));
        else
          wr_txn(8'hA0, 8'($urandom_range(0, 9)),
                 int'($urandom_range(1, 3)));
      end else if (kind <= 7) begin
        rd_txn(8'($urandom_range(0, 8)),
               int'($urandom_range(1, 3)));
      end else if (kind == 8) begin
        int_clear();
      end
      idle_gap(int'($urandom_range(5, 20)));
    end

    chk_idle = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
